// File: rtl/sqrt_unit_param_if.sv
// -----------------------------------------------------------------------------
// sqrt_unit_param_if
// Purpose : groups the operand-side and result-side ready/valid handshakes of
//           the integer square-root engine into one bundle.
// Parameter: WIDTH  operand width (root width RW = WIDTH/2 is derived)
// Signals  : in_valid_i / in_ready_o / x_i        operand handshake + operand
//            out_valid_o / out_ready_i / root_o   result handshake + root
//            rem_o                                remainder (SQRT_REM_EN only)
//            busy_o                               engine not idle
// Modports : master (stimulus side), slave (the engine)
// Optional : `define SQRT_REM_EN adds the rem_o signal to both modports.
// -----------------------------------------------------------------------------
interface sqrt_unit_param_if #(
  parameter int WIDTH = 8
);
  localparam int RW = WIDTH / 2;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] x_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [RW-1:0]    root_o;
`ifdef SQRT_REM_EN
  logic [RW:0]      rem_o;
`endif
  logic             busy_o;

`ifdef SQRT_REM_EN
  modport master (
    output in_valid_i, x_i, out_ready_i,
    input  in_ready_o, out_valid_o, root_o, rem_o, busy_o
  );
  modport slave (
    input  in_valid_i, x_i, out_ready_i,
    output in_ready_o, out_valid_o, root_o, rem_o, busy_o
  );
`else
  modport master (
    output in_valid_i, x_i, out_ready_i,
    input  in_ready_o, out_valid_o, root_o, busy_o
  );
  modport slave (
    input  in_valid_i, x_i, out_ready_i,
    output in_ready_o, out_valid_o, root_o, busy_o
  );
`endif
endinterface

// File: rtl/sqrt_unit_param.sv
// -----------------------------------------------------------------------------
// sqrt_unit_param
// Purpose : integer square root, root = floor(sqrt(x)) of an unsigned WIDTH-bit
//           operand, restoring digit-by-digit method, one root bit per clock.
//           One operation in flight: IDLE -> CALC (RW cycles) -> DONE -> IDLE.
// Ports   : clk_i  clock (rising edge)
//           rst_i  asynchronous active-high reset
//           bus    sqrt_unit_param_if.slave
//                    in_valid_i/in_ready_o/x_i       operand handshake
//                    out_valid_o/out_ready_i/root_o  result handshake
//                    rem_o  x - root^2 (only with SQRT_REM_EN)
//                    busy_o state != IDLE
// Optional: `define SQRT_REM_EN exposes the remainder on rem_o. Without it the
//           accumulator is still kept internally; root and latency unchanged.
// -----------------------------------------------------------------------------
module sqrt_unit_param #(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sqrt_unit_param_if.slave  bus
);

  localparam int RW = WIDTH / 2;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("sqrt_unit_param: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_op;    // operand, consumed two bits per iteration from the top
  logic [RW+1:0]    r_acc;   // partial remainder
  logic [RW-1:0]    r_root;  // root built MSB first
  logic [CW-1:0]    r_cnt;   // iterations left minus one

  logic [RW+1:0]    w_acc_sh;
  logic [RW+1:0]    w_trial;
  logic [RW+1:0]    w_diff;
  logic             w_ge;
  logic             w_accept;
  logic             w_last;
  logic             w_unused;

  // The stored partial remainder never exceeds 2*root, so before the shift it
  // fits in RW bits; the shifted value then fits in the RW+2-bit trial width.
  assign w_acc_sh = {r_acc[RW-1:0], r_op[WIDTH-1 -: 2]};
  assign w_trial  = {r_root, 2'b01};
  assign w_ge     = (w_acc_sh >= w_trial);
  assign w_diff   = w_acc_sh - w_trial;
  assign w_unused = ^r_acc[RW+1:RW];

  assign w_accept = (r_state == S_IDLE) && bus.in_valid_i;
  assign w_last   = (r_cnt == '0);

  // In reset the state is already IDLE, so ready is gated by rst_i directly.
  assign bus.in_ready_o  = (r_state == S_IDLE) && !rst_i;
  assign bus.out_valid_o = (r_state == S_DONE);
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.root_o      = r_root;
`ifdef SQRT_REM_EN
  assign bus.rem_o       = r_acc[RW:0];
`endif

  // ---- control: state register ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept)           w_state_nxt = S_CALC;
      S_CALC: if (w_last)             w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready_i)    w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  // ---- datapath: load on accept, one root bit per CALC cycle, hold in DONE ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op   <= '0;
      r_acc  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.x_i;
        r_acc  <= '0;
        r_root <= '0;
        r_cnt  <= CW'(RW - 1);
      end else if (r_state == S_CALC) begin
        r_op <= r_op << 2;
        if (w_ge) begin
          r_acc  <= w_diff;
          r_root <= (r_root << 1) | RW'(1);
        end else begin
          r_acc  <= w_acc_sh;
          r_root <= r_root << 1;
        end
        if (!w_last) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sqrt_unit_param.sv
// -----------------------------------------------------------------------------
// tb_sqrt_unit_param
// Directed and randomized checks of sqrt_unit_param at WIDTH=8 and WIDTH=16
// against an arithmetic reference (smallest-r search for floor(sqrt(x))).
// Remainder checks are compiled in when SQRT_REM_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sqrt_unit_param;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  sqrt_unit_param_if #(.WIDTH(8))  if8 ();
  sqrt_unit_param_if #(.WIDTH(16)) if16 ();

  sqrt_unit_param #(.WIDTH(8)) u_dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if8.slave)
  );

  sqrt_unit_param #(.WIDTH(16)) u_dut16 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint unsigned ref_root(input longint unsigned x);
    longint unsigned r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation up to the first DONE cycle. x_i is scrambled during
  // CALC. lat counts edges from the accept edge to the one raising out_valid.
  task automatic op8(input logic [7:0] x, input bit early,
                     output logic [63:0] root, output logic [63:0] rem, output int lat);
    int g;
    g = 0;
    while (if8.in_ready_o !== 1'b1 && g < 100) begin tick(); g++; end
    check("op8_in_ready", if8.in_ready_o, 1);
    if8.x_i         = x;
    if8.in_valid_i  = 1'b1;
    if8.out_ready_i = early;
    tick();
    if8.in_valid_i = 1'b0;
    lat = 0;
    while (if8.out_valid_o !== 1'b1 && lat < 100) begin
      if8.x_i = 8'($urandom);
      tick();
      lat++;
    end
    root = 64'(if8.root_o);
`ifdef SQRT_REM_EN
    rem = 64'(if8.rem_o);
`else
    rem = 64'(x) - 64'(if8.root_o) * 64'(if8.root_o);
`endif
  endtask

  task automatic ack8();
    if8.out_ready_i = 1'b1;
    tick();
    if8.out_ready_i = 1'b0;
  endtask

  task automatic op16(input logic [15:0] x,
                      output logic [63:0] root, output logic [63:0] rem, output int lat);
    int g;
    g = 0;
    while (if16.in_ready_o !== 1'b1 && g < 100) begin tick(); g++; end
    if (if16.in_ready_o !== 1'b1) check("op16_in_ready", if16.in_ready_o, 1);
    if16.x_i        = x;
    if16.in_valid_i = 1'b1;
    tick();
    if16.in_valid_i = 1'b0;
    lat = 0;
    while (if16.out_valid_o !== 1'b1 && lat < 100) begin
      if16.x_i = 16'($urandom);
      tick();
      lat++;
    end
    root = 64'(if16.root_o);
`ifdef SQRT_REM_EN
    rem = 64'(if16.rem_o);
`else
    rem = 64'(x) - 64'(if16.root_o) * 64'(if16.root_o);
`endif
  endtask

  // Checks one finished WIDTH=8 result against the reference.
  task automatic expect8(input string tag, input logic [7:0] x,
                         input logic [63:0] root, input logic [63:0] rem, input int lat);
    longint unsigned r;
    r = ref_root(64'(x));
    check({tag, "_root"}, root, r);
`ifdef SQRT_REM_EN
    check({tag, "_rem"}, rem, 64'(x) - r * r);
`endif
    check({tag, "_lat"}, 64'(lat), 4);
  endtask

  logic [63:0] root, rem, held;
  int          lat;
  bit          seen;
  logic [7:0]  x8;
  logic [15:0] x16;
  longint unsigned r;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    if8.in_valid_i  = 1'b0; if8.x_i  = '0; if8.out_ready_i  = 1'b0;
    if16.in_valid_i = 1'b0; if16.x_i = '0; if16.out_ready_i = 1'b0;
    tick(); tick();

    // reset values
    check("rst_in_ready", if8.in_ready_o, 0);
    check("rst_out_valid", if8.out_valid_o, 0);
    check("rst_root", if8.root_o, 0);
    check("rst_busy", if8.busy_o, 0);
`ifdef SQRT_REM_EN
    check("rst_rem", if8.rem_o, 0);
`endif
    rst = 1'b0;
    tick();
    check("idle_in_ready", if8.in_ready_o, 1);

    // directed boundary values
    op8(8'd0, 1'b0, root, rem, lat);   expect8("x0", 8'd0, root, rem, lat);
    check("x0_root_const", root, 0);
    ack8();
    op8(8'd255, 1'b0, root, rem, lat); expect8("x255", 8'd255, root, rem, lat);
    check("x255_root_const", root, 15);
`ifdef SQRT_REM_EN
    check("x255_rem_const", rem, 30);
`endif
    ack8();
    op8(8'd144, 1'b0, root, rem, lat); expect8("x144", 8'd144, root, rem, lat);
    check("x144_root_const", root, 12);
    ack8();
    op8(8'd143, 1'b0, root, rem, lat); expect8("x143", 8'd143, root, rem, lat);
    check("x143_root_const", root, 11);
`ifdef SQRT_REM_EN
    check("x143_rem_const", rem, 22);
`endif
    ack8();

    // back-pressure: result held for 10 cycles
    op8(8'd99, 1'b0, root, rem, lat); expect8("bp", 8'd99, root, rem, lat);
    held = root;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", if8.out_valid_o, 1);
      check("bp_root_stable", if8.root_o, held);
      check("bp_in_ready", if8.in_ready_o, 0);
`ifdef SQRT_REM_EN
      check("bp_rem_stable", if8.rem_o, 18);
`endif
    end
    ack8();
    check("bp_release_idle", if8.in_ready_o, 1);
    check("bp_release_busy", if8.busy_o, 0);
    op8(8'd50, 1'b0, root, rem, lat); expect8("x50", 8'd50, root, rem, lat);
    check("x50_root_const", root, 7);
    ack8();

    // out_ready held high before DONE: one DONE cycle only
    op8(8'd81, 1'b1, root, rem, lat); expect8("early", 8'd81, root, rem, lat);
    tick();
    check("early_out_valid_drop", if8.out_valid_o, 0);
    check("early_in_ready", if8.in_ready_o, 1);
    if8.out_ready_i = 1'b0;

    // reset in the middle of CALC
    if8.x_i = 8'd200; if8.in_valid_i = 1'b1;
    tick();
    if8.in_valid_i = 1'b0;
    tick(); tick();
    check("midcalc_busy_before", if8.busy_o, 1);
    rst = 1'b1;
    #1;
    check("midcalc_rst_out_valid", if8.out_valid_o, 0);
    check("midcalc_rst_busy", if8.busy_o, 0);
    check("midcalc_rst_in_ready", if8.in_ready_o, 0);
    check("midcalc_rst_root", if8.root_o, 0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if8.out_valid_o !== 1'b0) seen = 1'b1;
    end
    check("midcalc_no_spurious_valid", seen, 0);
    check("midcalc_in_ready_after", if8.in_ready_o, 1);
    op8(8'd200, 1'b0, root, rem, lat); expect8("x200", 8'd200, root, rem, lat);
    check("x200_root_const", root, 14);
`ifdef SQRT_REM_EN
    check("x200_rem_const", rem, 4);
`endif

    // reset while result waits in DONE
    tick();
    rst = 1'b1;
    #1;
    check("middone_rst_out_valid", if8.out_valid_o, 0);
    check("middone_rst_root", if8.root_o, 0);
    tick();
    rst = 1'b0;
    tick();
    check("middone_in_ready_after", if8.in_ready_o, 1);
    check("middone_out_valid_after", if8.out_valid_o, 0);

    // WIDTH=8 random
    for (int i = 0; i < 40; i++) begin
      x8 = 8'($urandom);
      op8(x8, 1'b0, root, rem, lat); expect8("rnd8", x8, root, rem, lat);
      ack8();
    end

    // WIDTH=16 random sweep
    for (int i = 0; i < 1000; i++) begin
      x16 = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h0000 : 16'($urandom);
      op16(x16, root, rem, lat);
      r = ref_root(64'(x16));
      check("rnd16_root", root, r);
      check("rnd16_lat", 64'(lat), 8);
`ifdef SQRT_REM_EN
      check("rnd16_sum", root * root + rem, 64'(x16));
      check("rnd16_rem_bound", 64'(rem <= 2 * root), 1);
`endif
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      if16.out_ready_i = 1'b1;
      tick();
      if16.out_ready_i = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
